vit_acs_array: RTL and testbench

- Registered, parametrised add-compare-select array for a rate-1/2 hard-decision Viterbi decoder; next generation of the single-state combinational ACS cell.
- Updates all 2^(K-1) path metrics in one clock per received symbol pair, and computes branch metrics internally from generator polynomials.
- Saturating "unreached" metric value, metric normalisation, per-state decision bits for the traceback unit, best-state/best-metric reporting.
- Sits between the symbol slicer and the traceback/survivor memory.

---
 rtl/vit_acs_array.sv | 101 ++++++++++
 tb/tb_vit_acs_array.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vit_acs_array.sv
// Registered add-compare-select array for a rate-1/2 hard-decision Viterbi decoder.
// One trellis step per valid symbol; metric normalisation and best-state search.
module vit_acs_array #(
  parameter int W = 4,
  parameter int K = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    sym_valid,
  input  logic [1:0]              rx_sym,
  output logic                    dec_valid,
  output logic [(1<<(K-1))-1:0]   dec_bits,
  output logic [K-2:0]            best_state,
  output logic [W-1:0]            best_metric,
  output logic                    norm_pulse
);

  localparam int NS = 1 << (K-1);
  localparam logic [W-1:0] INF  = '1;
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] pm     [NS];
  logic [W-1:0] sum0   [NS];
  logic [W-1:0] sum1   [NS];
  logic [W-1:0] pm_acs [NS];
  logic [W-1:0] pm_nxt [NS];
  logic [NS-1:0] dec_nxt;
  logic          all_high;
  logic [K-2:0]  best_s;
  logic [W-1:0]  best_m;

  function automatic logic [1:0] hamming(input logic [1:0] x);
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  // An unreached metric stays unreached; finite sums clamp at all-ones.
  function automatic logic [W-1:0] add_sat(input logic [W-1:0] m, input logic [1:0] bm);
    logic [W:0] s;
    if (m == INF) return INF;
    s = {1'b0, m} + {{(W-1){1'b0}}, bm};
    return s[W] ? INF : s[W-1:0];
  endfunction

  for (genvar g = 0; g < NS; g++) begin : g_acs
    localparam logic [K-2:0] SN = (K-1)'(g);
    localparam logic [K-2:0] P0 = {SN[K-3:0], 1'b0};
    localparam logic [K-2:0] P1 = {SN[K-3:0], 1'b1};
    localparam logic [K-1:0] R0 = {SN[K-2], P0};
    localparam logic [K-1:0] R1 = {SN[K-2], P1};
    localparam logic [1:0]   C0 = {^(R0 & G1), ^(R0 & G0)};
    localparam logic [1:0]   C1 = {^(R1 & G1), ^(R1 & G0)};

    assign sum0[g]    = add_sat(pm[P0], hamming(rx_sym ^ C0));
    assign sum1[g]    = add_sat(pm[P1], hamming(rx_sym ^ C1));
    // Ties go to the upper predecessor.
    assign dec_nxt[g] = sum1[g] < sum0[g];
    assign pm_acs[g]  = dec_nxt[g] ? sum1[g] : sum0[g];
  end

  always_comb begin
    all_high = 1'b1;
    for (int s = 0; s < NS; s++)
      if (!pm_acs[s][W-1]) all_high = 1'b0;
    for (int s = 0; s < NS; s++)
      pm_nxt[s] = (all_high && pm_acs[s] != INF) ? pm_acs[s] - HALF : pm_acs[s];
  end

  always_comb begin
    best_s = '0;
    best_m = pm_nxt[0];
    for (int s = 1; s < NS; s++)
      if (pm_nxt[s] < best_m) begin
        best_s = (K-1)'(s);
        best_m = pm_nxt[s];
      end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      for (int s = 0; s < NS; s++) pm[s] <= (s == 0) ? '0 : INF;
      dec_valid   <= 1'b0;
      dec_bits    <= '0;
      best_state  <= '0;
      best_metric <= '0;
      norm_pulse  <= 1'b0;
    end else begin
      dec_valid <= sym_valid;
      if (sym_valid) begin
        for (int s = 0; s < NS; s++) pm[s] <= pm_nxt[s];
        dec_bits    <= dec_nxt;
        best_state  <= best_s;
        best_metric <= best_m;
        norm_pulse  <= all_high;
      end
    end
  end

endmodule

// File: tb/tb_vit_acs_array.sv
// Directed bench for vit_acs_array (K=3, W=4, G0=111, G1=101) with a
// forward-push trellis model for the long run.
module tb_vit_acs_array;

  logic       clk = 1'b0;
  logic       reset, start, sym_valid;
  logic [1:0] rx_sym;
  logic       dec_valid;
  logic [3:0] dec_bits;
  logic [1:0] best_state;
  logic [3:0] best_metric;
  logic       norm_pulse;

  int checks = 0;
  int errors = 0;

  vit_acs_array #(.W(4), .K(3), .G0(3'b111), .G1(3'b101)) dut (
    .clk(clk), .reset(reset), .start(start), .sym_valid(sym_valid), .rx_sym(rx_sym),
    .dec_valid(dec_valid), .dec_bits(dec_bits), .best_state(best_state),
    .best_metric(best_metric), .norm_pulse(norm_pulse)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic cycle(input logic v, input logic [1:0] sym, input logic st, input logic rst);
    sym_valid = v; rx_sym = sym; start = st; reset = rst;
    @(posedge clk); #1;
    sym_valid = 1'b0; start = 1'b0; reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pm(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, ".pm0"}, 32'(dut.pm[0]), 32'(e0));
    chk({tag, ".pm1"}, 32'(dut.pm[1]), 32'(e1));
    chk({tag, ".pm2"}, 32'(dut.pm[2]), 32'(e2));
    chk({tag, ".pm3"}, 32'(dut.pm[3]), 32'(e3));
  endtask

  task automatic chk_out(input string tag, input int dv, input int db, input int bs,
                         input int bm, input int np);
    chk({tag, ".dec_valid"},   32'(dec_valid),   32'(dv));
    chk({tag, ".dec_bits"},    32'(dec_bits),    32'(db));
    chk({tag, ".best_state"},  32'(best_state),  32'(bs));
    chk({tag, ".best_metric"}, 32'(best_metric), 32'(bm));
    chk({tag, ".norm_pulse"},  32'(norm_pulse),  32'(np));
  endtask

  // Reference trellis: push every (state, input) transition forward.
  int m_pm [4];
  int m_dec, m_best, m_bmin, m_norm;

  function automatic logic [1:0] enc(input int u, input int p);
    logic [2:0] r;
    r = {u[0], p[1], p[0]};
    return {^(r & 3'b101), ^(r & 3'b111)};
  endfunction

  task automatic model_reset();
    m_pm = '{0, 15, 15, 15};
  endtask

  task automatic model_step(input logic [1:0] sym);
    int cand [4];
    int sn, d, sm;
    logic [1:0] x;
    m_dec = 0;
    for (int p = 0; p < 4; p++)
      for (int u = 0; u < 2; u++) begin
        sn = u * 2 + p / 2;
        x = sym ^ enc(u, p);
        d = int'(x[0]) + int'(x[1]);
        sm = (m_pm[p] == 15) ? 15 : ((m_pm[p] + d > 15) ? 15 : m_pm[p] + d);
        if (p % 2 == 0) cand[sn] = sm;
        else if (sm < cand[sn]) begin
          cand[sn] = sm;
          m_dec = m_dec | (1 << sn);
        end
      end
    m_norm = 1;
    for (int s = 0; s < 4; s++) if (cand[s] < 8) m_norm = 0;
    for (int s = 0; s < 4; s++) m_pm[s] = (m_norm == 1 && cand[s] != 15) ? cand[s] - 8 : cand[s];
    m_best = 0; m_bmin = m_pm[0];
    for (int s = 1; s < 4; s++) if (m_pm[s] < m_bmin) begin m_best = s; m_bmin = m_pm[s]; end
  endtask

  logic [3:0] tb_dec [3];
  logic [1:0] tr_state;
  logic [2:0] tr_bits;
  int norm_seen, min_obs;

  initial begin
    reset = 1'b1; start = 1'b0; sym_valid = 1'b0; rx_sym = 2'b00;
    cycle(0, 2'b00, 0, 1);
    cycle(0, 2'b00, 0, 1);

    // Reset state
    chk_out("rst", 0, 0, 0, 0, 0);
    chk_pm("rst", 0, 15, 15, 15);

    // Single all-zero symbol
    cycle(1, 2'b00, 0, 0);
    chk_out("s1", 1, 4'b0000, 0, 0, 0);
    chk_pm("s1", 0, 15, 2, 15);
    cycle(0, 2'b00, 0, 0);
    chk("s1.pulse_end", 32'(dec_valid), 32'd0);

    // Error-free codeword for inputs 1,0,0 ({c1,c0} = 11, 01, 11)
    cycle(0, 2'b00, 0, 1);
    cycle(1, 2'b11, 0, 0);
    tb_dec[0] = dec_bits;
    chk_out("cw1", 1, 4'b0000, 2, 0, 0);
    chk_pm("cw1", 2, 15, 0, 15);
    cycle(1, 2'b01, 0, 0);
    tb_dec[1] = dec_bits;
    chk_out("cw2", 1, 4'b0000, 1, 0, 0);
    chk_pm("cw2", 3, 0, 3, 2);
    cycle(1, 2'b11, 0, 0);
    tb_dec[2] = dec_bits;
    chk_out("cw3", 1, 4'b1111, 0, 0, 0);
    chk_pm("cw3", 0, 3, 2, 3);
    tr_state = best_state;
    for (int t = 2; t >= 0; t--) begin
      tr_bits[t] = tr_state[1];
      tr_state = {tr_state[0], tb_dec[t][tr_state]};
    end
    chk("cw.traceback", 32'(tr_bits), 32'(3'b001));

    // Idle gap: everything holds, dec_valid low
    for (int i = 0; i < 5; i++) begin
      cycle(0, 2'(i), 0, 0);
      chk_out("gap", 0, 4'b1111, 0, 0, 0);
      chk_pm("gap", 0, 3, 2, 3);
    end
    cycle(1, 2'b00, 0, 0);
    chk_out("after_gap", 1, 4'b0000, 0, 0, 0);
    chk_pm("after_gap", 0, 3, 2, 3);

    // start with a simultaneous valid symbol: symbol discarded
    cycle(1, 2'b11, 1, 0);
    chk_out("start", 0, 0, 0, 0, 0);
    chk_pm("start", 0, 15, 15, 15);
    cycle(1, 2'b00, 0, 0);
    chk_out("start_s1", 1, 4'b0000, 0, 0, 0);
    chk_pm("start_s1", 0, 15, 2, 15);

    // Ties: unreached-vs-unreached picks upper; equal minima report lowest state
    cycle(0, 2'b00, 0, 1);
    cycle(1, 2'b00, 0, 0);
    chk("tie1.dec_bits", 32'(dec_bits), 32'(4'b0000));
    cycle(1, 2'b01, 0, 0);
    chk_out("tie2", 1, 4'b0000, 0, 1, 0);
    chk_pm("tie2", 1, 2, 1, 4);

    // Long run of 11 against the reference trellis
    cycle(0, 2'b00, 0, 1);
    model_reset();
    norm_seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 2'b11, 0, 0);
      model_step(2'b11);
      chk_out($sformatf("run%0d", i), 1, m_dec, m_best, m_bmin, m_norm);
      chk_pm($sformatf("run%0d", i), m_pm[0], m_pm[1], m_pm[2], m_pm[3]);
      min_obs = 15;
      for (int s = 0; s < 4; s++) if (int'(dut.pm[s]) < min_obs) min_obs = int'(dut.pm[s]);
      chk($sformatf("run%0d.min_below_half", i), 32'(min_obs < 8), 32'd1);
      if (norm_pulse) norm_seen++;
    end
    chk("run.norm_seen", 32'(norm_seen > 0), 32'd1);

    // Reset mid-stream, then step 0 of a new frame
    cycle(1, 2'b11, 0, 1);
    chk_out("rst2", 0, 0, 0, 0, 0);
    chk_pm("rst2", 0, 15, 15, 15);
    cycle(1, 2'b00, 0, 0);
    chk_pm("rst2_s1", 0, 15, 2, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
